foa_step_gen: RTL and testbench
===============================

FOA_STEP_GEN -- requirements
Module: foa_step_gen

Interface
REQ-001 The block SHALL have parameter phase_bits, default 10, the width of a frequency step magnitude.
REQ-002 The block SHALL have parameter foas, default 3, the number of frequency-offset bins emitted per sweep.
REQ-003 The block SHALL have parameter foas_counter_bits, default 3, the width of the bin index.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset: synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit, a sweep request sampled only in IDLE.
REQ-007 The block SHALL have port delta, input, phase_bits, the bin spacing, captured on an accepted start.
REQ-008 The block SHALL have port m_axis_freq_step_tvalid, output, 1 bit, a step word is presented.
REQ-009 The block SHALL have port m_axis_freq_step_tready, input, 1 bit, the consumer accepts the word.
REQ-010 The block SHALL have port freq_step, output, phase_bits, the offset magnitude.
REQ-011 The block SHALL have port neg_shift, output, 1 bit, 1 when the offset is negative.
REQ-012 The block SHALL have port freq_step_index, output, foas_counter_bits, the bin number k of the current word.
REQ-013 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the last bin is accepted.
REQ-015 The block SHALL have port overflow, output, 1 bit, sticky: a magnitude exceeded 2^phase_bits-1 during the sweep.

Function
REQ-016 The block SHALL emit, for k = 0..foas-1, the offset (k - h)*delta, where h = (foas-1)/2 with integer division.
REQ-017 The block SHALL implement states IDLE, PREP, EMIT and DONE: IDLE->PREP on start; PREP->EMIT when magnitude = h*delta; EMIT->DONE on the handshake of bin foas-1; DONE->IDLE after one cycle.
REQ-018 PREP SHALL form h*delta by h repeated additions with no multiplier, taking max(h,1) cycles, with neg_shift = 1 if h > 0.
REQ-019 In EMIT, m_axis_freq_step_tvalid SHALL be high, with freq_step, neg_shift and freq_step_index held stable until the cycle in which m_axis_freq_step_tready is high.
REQ-020 On each EMIT handshake, the block SHALL subtract delta from the magnitude if neg_shift = 1, otherwise add delta; it SHALL clear neg_shift when the magnitude reaches 0 and increment freq_step_index.
REQ-021 A zero offset SHALL be presented as freq_step = 0 with neg_shift = 0.
REQ-022 When delta = 0, all bins SHALL be emitted as 0 with neg_shift = 0.
REQ-023 start SHALL be ignored while busy is high.
REQ-024 Back-to-back handshakes SHALL sustain one word per cycle.
REQ-025 tvalid SHALL be low in IDLE, PREP and DONE.
REQ-026 The block SHALL clear overflow on an accepted start.

Reset
REQ-027 When rst is high, the block SHALL enter IDLE within one clock, regardless of state, including mid-sweep.
REQ-028 While rst is high, the outputs SHALL be: m_axis_freq_step_tvalid=0, freq_step=0, neg_shift=0, freq_step_index=0, busy=0, done=0, overflow=0.
REQ-029 A word pending at reset SHALL be dropped without completing its handshake.

Configuration
REQ-030 With FOA_STEP_GEN_SATURATE_EN defined, the block SHALL clamp any magnitude that overflows to 2^phase_bits-1 and set overflow.
REQ-031 Without FOA_STEP_GEN_SATURATE_EN, the block SHALL wrap the magnitude modulo 2^phase_bits and still set overflow.

Structure
REQ-032 The state encoding localparams (IDLE=2'b00, PREP=2'b01, EMIT=2'b10, DONE=2'b11) SHALL reside in shared package caf_pkg, alongside the default phase_bits.
REQ-033 The block SHALL be a single module with no sub-module; the accumulator is inline.

Verification
REQ-034 Test: foas=3, delta=5, tready=1 -> words (5,neg=1,k=0), (0,0,1), (5,0,2); done one cycle after k=2.
REQ-035 Test: foas=4, delta=7 -> offsets -7, 0, 7, 14 with k = 0..3.
REQ-036 Test: tready toggling 1,0,0,1 -> the word is held stable across stalls; no bin skipped or duplicated.
REQ-037 Test: phase_bits=4, foas=5, delta=9 -> last bin 18 gives 15 (saturate) or 2 (wrap); overflow=1 in both builds.
REQ-038 Test: rst asserted at k=1 -> tvalid=0 and busy=0 next cycle; a new start restarts at k=0.
REQ-039 Test: start pulsed during EMIT -> ignored; the sweep completes unchanged and delta is not recaptured.

Source files
------------

// File: rtl/caf_pkg.sv
// Shared constants for the frequency-offset step generator: FSM state encoding and default step width.
package caf_pkg;

    localparam int PHASE_BITS_DEFAULT = 10;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t PREP = 2'b01;
    localparam state_t EMIT = 2'b10;
    localparam state_t DONE = 2'b11;

endpackage

// File: rtl/foa_step_gen_if.sv
// AXI-Stream style bundle carrying one frequency-step word per handshake.
interface foa_step_gen_if
    import caf_pkg::*;
#(
    parameter int phase_bits        = PHASE_BITS_DEFAULT,
    parameter int foas_counter_bits = 3
);
    logic                         m_axis_freq_step_tvalid;
    logic                         m_axis_freq_step_tready;
    logic [phase_bits-1:0]        freq_step;
    logic                         neg_shift;
    logic [foas_counter_bits-1:0] freq_step_index;

    modport master (
        output m_axis_freq_step_tvalid,
        input  m_axis_freq_step_tready,
        output freq_step,
        output neg_shift,
        output freq_step_index
    );

    modport slave (
        input  m_axis_freq_step_tvalid,
        output m_axis_freq_step_tready,
        input  freq_step,
        input  neg_shift,
        input  freq_step_index
    );
endinterface

// File: rtl/foa_step_gen.sv
// Emits the signed offsets (k-h)*delta, k = 0..foas-1, as magnitude/sign words on a valid/ready stream.
// FOA_STEP_GEN_SATURATE_EN: clamp overflowing magnitudes to all-ones instead of wrapping.
module foa_step_gen
    import caf_pkg::*;
#(
    parameter int phase_bits        = PHASE_BITS_DEFAULT,
    parameter int foas              = 3,
    parameter int foas_counter_bits = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [phase_bits-1:0] delta,
    foa_step_gen_if.master        m_axis,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int H = (foas - 1) / 2;
    localparam logic [foas_counter_bits-1:0] LAST_K    = foas_counter_bits'(foas - 1);
    localparam logic [foas_counter_bits-1:0] PREP_LAST = foas_counter_bits'((H > 0) ? H - 1 : 0);

    state_t                       state_q, state_d;
    logic [phase_bits-1:0]        mag_q, mag_d;
    logic [phase_bits-1:0]        delta_q, delta_d;
    logic                         neg_q, neg_d;
    logic [foas_counter_bits-1:0] idx_q, idx_d;
    logic [foas_counter_bits-1:0] cnt_q, cnt_d;
    logic                         tvalid_q, tvalid_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         ovf_q, ovf_d;

    logic [phase_bits:0]          sum_full, diff_full;
    logic [phase_bits-1:0]        add_res, sub_res, prep_mag;
    logic                         carry, borrow;

    // One shared adder/subtractor serves both the PREP accumulation and the EMIT stepping.
    always_comb begin
        sum_full  = {1'b0, mag_q} + {1'b0, delta_q};
        diff_full = {1'b0, mag_q} - {1'b0, delta_q};
        carry     = sum_full[phase_bits];
        borrow    = diff_full[phase_bits];
`ifdef FOA_STEP_GEN_SATURATE_EN
        add_res   = carry  ? {phase_bits{1'b1}} : sum_full[phase_bits-1:0];
        sub_res   = borrow ? {phase_bits{1'b0}} : diff_full[phase_bits-1:0];
`else
        add_res   = sum_full[phase_bits-1:0];
        sub_res   = diff_full[phase_bits-1:0];
`endif
        prep_mag  = (H > 0) ? add_res : mag_q;
    end

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        delta_d  = delta_q;
        neg_d    = neg_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        tvalid_d = tvalid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PREP;
                    delta_d = delta;
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            PREP: begin
                if (H > 0) begin
                    mag_d = prep_mag;
                    ovf_d = ovf_q | carry;
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_q == PREP_LAST) begin
                    state_d  = EMIT;
                    tvalid_d = 1'b1;
                    // A zero magnitude is always reported as a non-negative offset.
                    neg_d    = (H > 0) && (prep_mag != '0);
                end
            end
            EMIT: begin
                if (m_axis.m_axis_freq_step_tready) begin
                    if (idx_q == LAST_K) begin
                        state_d  = DONE;
                        tvalid_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (neg_q) begin
                            mag_d = sub_res;
                            ovf_d = ovf_q | borrow;
                            if (sub_res == '0) neg_d = 1'b0;
                        end else begin
                            mag_d = add_res;
                            ovf_d = ovf_q | carry;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            delta_q  <= '0;
            neg_q    <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            delta_q  <= delta_d;
            neg_q    <= neg_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign m_axis.m_axis_freq_step_tvalid = tvalid_q;
    assign m_axis.freq_step               = mag_q;
    assign m_axis.neg_shift               = neg_q;
    assign m_axis.freq_step_index         = idx_q;
    assign busy                           = busy_q;
    assign done                           = done_q;
    assign overflow                       = ovf_q;

endmodule

// File: tb/tb_foa_step_gen.sv
// Directed bench for foa_step_gen: a cycle table on the default 3-bin instance plus sequences
// for 4 bins, a narrow overflowing instance and reset in mid-sweep.
module tb_foa_step_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: defaults (10-bit, 3 bins)
    logic       start_a = 1'b0;
    logic [9:0] delta_a = '0;
    logic       busy_a, done_a, ovf_a;
    foa_step_gen_if #(.phase_bits(10), .foas_counter_bits(3)) if_a ();
    foa_step_gen #(.phase_bits(10), .foas(3), .foas_counter_bits(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .delta(delta_a), .m_axis(if_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a));

    // Instance B: 4-bit magnitude, 5 bins
    logic       start_b = 1'b0;
    logic [3:0] delta_b = '0;
    logic       busy_b, done_b, ovf_b;
    foa_step_gen_if #(.phase_bits(4), .foas_counter_bits(3)) if_b ();
    foa_step_gen #(.phase_bits(4), .foas(5), .foas_counter_bits(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .delta(delta_b), .m_axis(if_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b));

    // Instance C: 10-bit, 4 bins
    logic       start_c = 1'b0;
    logic [9:0] delta_c = '0;
    logic       busy_c, done_c, ovf_c;
    foa_step_gen_if #(.phase_bits(10), .foas_counter_bits(3)) if_c ();
    foa_step_gen #(.phase_bits(10), .foas(4), .foas_counter_bits(3)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .delta(delta_c), .m_axis(if_c),
        .busy(busy_c), .done(done_c), .overflow(ovf_c));

    typedef struct {
        logic       start;
        logic [9:0] delta;
        logic       tready;
        logic       tvalid;
        logic [9:0] step;
        logic       neg;
        logic [2:0] k;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[27];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mk(logic s, logic [9:0] d, logic tr, logic tv, logic [9:0] st,
                                logic ng, logic [2:0] k, logic b, logic dn);
        vec_t v;
        v.start = s; v.delta = d; v.tready = tr; v.tvalid = tv; v.step = st;
        v.neg = ng; v.k = k; v.busy = b; v.done = dn;
        return v;
    endfunction

    initial begin
        logic [9:0] exp_c_step[4];
        logic       exp_c_neg[4];
        int         n_words;
        logic       seen_done;
        logic [3:0] last_b_step;
        logic [3:0] exp_b_last;
        logic [2:0] last_b_k;

        if_a.m_axis_freq_step_tready = 1'b1;
        if_b.m_axis_freq_step_tready = 1'b1;
        if_c.m_axis_freq_step_tready = 1'b1;

        //        start delta tr | tv step neg k busy done
        vecs[0]  = mk(1, 5, 1,  0, 0, 0, 0, 1, 0);   // PREP
        vecs[1]  = mk(0, 5, 1,  1, 5, 1, 0, 1, 0);   // -5
        vecs[2]  = mk(0, 5, 1,  1, 0, 0, 1, 1, 0);   // 0
        vecs[3]  = mk(0, 5, 1,  1, 5, 0, 2, 1, 0);   // +5
        vecs[4]  = mk(0, 5, 1,  0, 0, 0, 0, 1, 1);   // DONE pulse
        vecs[5]  = mk(0, 5, 1,  0, 0, 0, 0, 0, 0);   // IDLE
        vecs[6]  = mk(1, 5, 1,  0, 0, 0, 0, 1, 0);   // stall sweep
        vecs[7]  = mk(0, 5, 1,  1, 5, 1, 0, 1, 0);
        vecs[8]  = mk(0, 5, 1,  1, 0, 0, 1, 1, 0);
        vecs[9]  = mk(0, 5, 0,  1, 0, 0, 1, 1, 0);
        vecs[10] = mk(0, 5, 0,  1, 0, 0, 1, 1, 0);
        vecs[11] = mk(0, 5, 1,  1, 5, 0, 2, 1, 0);
        vecs[12] = mk(0, 5, 1,  0, 0, 0, 0, 1, 1);
        vecs[13] = mk(0, 5, 1,  0, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 5, 1,  0, 0, 0, 0, 1, 0);   // start during EMIT
        vecs[15] = mk(0, 5, 0,  1, 5, 1, 0, 1, 0);
        vecs[16] = mk(1, 9, 0,  1, 5, 1, 0, 1, 0);
        vecs[17] = mk(0, 9, 1,  1, 0, 0, 1, 1, 0);
        vecs[18] = mk(1, 9, 1,  1, 5, 0, 2, 1, 0);
        vecs[19] = mk(0, 9, 1,  0, 0, 0, 0, 1, 1);
        vecs[20] = mk(0, 9, 1,  0, 0, 0, 0, 0, 0);
        vecs[21] = mk(1, 0, 1,  0, 0, 0, 0, 1, 0);   // delta = 0
        vecs[22] = mk(0, 0, 1,  1, 0, 0, 0, 1, 0);
        vecs[23] = mk(0, 0, 1,  1, 0, 0, 1, 1, 0);
        vecs[24] = mk(0, 0, 1,  1, 0, 0, 2, 1, 0);
        vecs[25] = mk(0, 0, 1,  0, 0, 0, 0, 1, 1);
        vecs[26] = mk(0, 0, 1,  0, 0, 0, 0, 0, 0);

        // Reset values on every instance
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid_a", 32'(if_a.m_axis_freq_step_tvalid), 0);
        chk("rst_step_a",   32'(if_a.freq_step), 0);
        chk("rst_neg_a",    32'(if_a.neg_shift), 0);
        chk("rst_k_a",      32'(if_a.freq_step_index), 0);
        chk("rst_busy_a",   32'(busy_a), 0);
        chk("rst_done_a",   32'(done_a), 0);
        chk("rst_ovf_a",    32'(ovf_a), 0);
        chk("rst_tvalid_b", 32'(if_b.m_axis_freq_step_tvalid), 0);
        chk("rst_busy_c",   32'(busy_c), 0);
        $display("reset check done");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            start_a = vecs[i].start;
            delta_a = vecs[i].delta;
            if_a.m_axis_freq_step_tready = vecs[i].tready;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_tvalid", i), 32'(if_a.m_axis_freq_step_tvalid), 32'(vecs[i].tvalid));
            chk($sformatf("row%0d_busy", i),   32'(busy_a), 32'(vecs[i].busy));
            chk($sformatf("row%0d_done", i),   32'(done_a), 32'(vecs[i].done));
            if (vecs[i].tvalid) begin
                chk($sformatf("row%0d_step", i), 32'(if_a.freq_step), 32'(vecs[i].step));
                chk($sformatf("row%0d_neg", i),  32'(if_a.neg_shift), 32'(vecs[i].neg));
                chk($sformatf("row%0d_k", i),    32'(if_a.freq_step_index), 32'(vecs[i].k));
            end
            $display("row %0d: tvalid=%0b step=%0d neg=%0b k=%0d busy=%0b done=%0b", i,
                     if_a.m_axis_freq_step_tvalid, if_a.freq_step, if_a.neg_shift,
                     if_a.freq_step_index, busy_a, done_a);
        end
        chk("ovf_a_clean", 32'(ovf_a), 0);

        // Four bins, delta 7: -7, 0, 7, 14
        exp_c_step[0] = 10'd7;  exp_c_neg[0] = 1'b1;
        exp_c_step[1] = 10'd0;  exp_c_neg[1] = 1'b0;
        exp_c_step[2] = 10'd7;  exp_c_neg[2] = 1'b0;
        exp_c_step[3] = 10'd14; exp_c_neg[3] = 1'b0;
        @(negedge clk);
        start_c = 1'b1; delta_c = 10'd7; if_c.m_axis_freq_step_tready = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        n_words = 0; seen_done = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            @(negedge clk);
            if (done_c) seen_done = 1'b1;
            if (if_c.m_axis_freq_step_tvalid && n_words < 4) begin
                chk($sformatf("c_step%0d", n_words), 32'(if_c.freq_step), 32'(exp_c_step[n_words]));
                chk($sformatf("c_neg%0d", n_words),  32'(if_c.neg_shift), 32'(exp_c_neg[n_words]));
                chk($sformatf("c_k%0d", n_words),    32'(if_c.freq_step_index), n_words);
                $display("c word: step=%0d neg=%0b k=%0d", if_c.freq_step, if_c.neg_shift,
                         if_c.freq_step_index);
                n_words++;
            end
        end
        chk("c_word_count", n_words, 4);
        chk("c_done_seen", 32'(seen_done), 1);

        // Narrow instance: last bin 18 overflows 4 bits
`ifdef FOA_STEP_GEN_SATURATE_EN
        exp_b_last = 4'd15;
`else
        exp_b_last = 4'd2;
`endif
        @(negedge clk);
        start_b = 1'b1; delta_b = 4'd9; if_b.m_axis_freq_step_tready = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n_words = 0; seen_done = 1'b0; last_b_step = '0; last_b_k = '0;
        for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            @(negedge clk);
            if (done_b) seen_done = 1'b1;
            if (if_b.m_axis_freq_step_tvalid) begin
                chk($sformatf("b_k%0d", n_words), 32'(if_b.freq_step_index), n_words);
                last_b_step = if_b.freq_step;
                last_b_k    = if_b.freq_step_index;
                $display("b word: step=%0d neg=%0b k=%0d", if_b.freq_step, if_b.neg_shift,
                         if_b.freq_step_index);
                n_words++;
            end
        end
        chk("b_word_count", n_words, 5);
        chk("b_done_seen", 32'(seen_done), 1);
        chk("b_last_k", 32'(last_b_k), 4);
        chk("b_last_step", 32'(last_b_step), 32'(exp_b_last));
        chk("b_overflow", 32'(ovf_b), 1);

        // Reset while bin 1 is presented
        @(negedge clk);
        start_a = 1'b1; delta_a = 10'd5; if_a.m_axis_freq_step_tready = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen_done; cyc++) begin
            @(negedge clk);
            if (if_a.m_axis_freq_step_tvalid && if_a.freq_step_index == 3'd1) seen_done = 1'b1;
        end
        chk("rst_mid_reached_k1", 32'(seen_done), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_tvalid", 32'(if_a.m_axis_freq_step_tvalid), 0);
        chk("rst_mid_busy",   32'(busy_a), 0);
        chk("rst_mid_k",      32'(if_a.freq_step_index), 0);
        chk("rst_mid_step",   32'(if_a.freq_step), 0);
        chk("rst_mid_neg",    32'(if_a.neg_shift), 0);
        $display("reset mid-sweep: tvalid=%0b busy=%0b", if_a.m_axis_freq_step_tvalid, busy_a);
        @(negedge clk);
        rst = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_tvalid", 32'(if_a.m_axis_freq_step_tvalid), 1);
        chk("restart_k",      32'(if_a.freq_step_index), 0);
        chk("restart_step",   32'(if_a.freq_step), 5);
        chk("restart_neg",    32'(if_a.neg_shift), 1);
        $display("restart: step=%0d neg=%0b k=%0d", if_a.freq_step, if_a.neg_shift,
                 if_a.freq_step_index);
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen_done; cyc++) begin
            @(negedge clk);
            if (done_a) seen_done = 1'b1;
        end
        chk("restart_done", 32'(seen_done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
